// File: rtl/load_store_unit.sv
// RISC-V byte/half/word load-store sequencer for a byte-write, registered 32-bit-read RAM.
// Stores take N cycles (one byte per cycle), loads take 2, illegal requests complete at acceptance; req_ready only in IDLE.
module load_store_unit #(
   parameter int ADDR_W = 6
) (
   input  logic              LSU_clk,
   input  logic              LSU_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_done,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              mem_WE,
   output logic [ADDR_W-1:0] mem_add,
   output logic [7:0]        mem_in,
   input  logic [31:0]       mem_out
);

   typedef enum logic [1:0] {IDLE, STORE, LOAD, CAPTURE} state_t;

   typedef struct packed {
      logic              we;
      logic [2:0]        funct3;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   state_t            state, state_nxt;
   req_t              req_q;
   logic [1:0]        byte_idx;
   logic [1:0]        last_idx;
   logic              accept;
   logic              req_legal;
   logic [ADDR_W-1:0] mem_add_q;
   logic [7:0]        mem_in_q;
   logic [31:0]       shifted;
   logic [31:0]       load_result;

   assign accept = req_valid & req_ready;

   // Width code maps to last byte index: 00->0, 01->1, 10->3.
   assign last_idx = {req_q.funct3[1], req_q.funct3[1] | req_q.funct3[0]};

   always_comb begin
      req_legal = 1'b0;
      case (req_funct3)
         3'b000:  req_legal = 1'b1;
         3'b001:  req_legal = ~req_addr[0];
         3'b010:  req_legal = (req_addr[1:0] == 2'b00);
         3'b100:  req_legal = ~req_we;
         3'b101:  req_legal = ~req_we & ~req_addr[0];
         default: req_legal = 1'b0;
      endcase
   end

   always_ff @(posedge LSU_clk) begin
      if (LSU_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && req_legal) state_nxt = req_we ? STORE : LOAD;
         STORE:   if (byte_idx == last_idx) state_nxt = IDLE;
         LOAD:    state_nxt = CAPTURE;
         CAPTURE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_add/mem_in replay their registered copies so they hold outside writes.
   always_comb begin
      req_ready = (state == IDLE);
      mem_WE    = 1'b0;
      mem_add   = mem_add_q;
      mem_in    = mem_in_q;
      case (state)
         STORE: begin
            mem_WE  = 1'b1;
            mem_add = req_q.addr + ADDR_W'(byte_idx);
            mem_in  = req_q.wdata[{byte_idx, 3'b000} +: 8];
         end
         LOAD:    mem_add = {req_q.addr[ADDR_W-1:2], 2'b00};
         default: ;
      endcase
   end

   assign shifted = mem_out >> {req_q.addr[1:0], 3'b000};

   always_comb begin
      case (req_q.funct3)
         3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_result = {24'd0, shifted[7:0]};
         3'b101:  load_result = {16'd0, shifted[15:0]};
         default: load_result = shifted;
      endcase
   end

   always_ff @(posedge LSU_clk) begin
      if (LSU_rst) begin
         req_q      <= '0;
         byte_idx   <= 2'd0;
         resp_done  <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         mem_add_q  <= '0;
         mem_in_q   <= 8'd0;
      end else begin
         resp_done <= 1'b0;
         mem_add_q <= mem_add;
         mem_in_q  <= mem_in;
         byte_idx  <= (state == STORE) ? byte_idx + 2'd1 : 2'd0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (req_legal) begin
                     req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                  end else begin
                     resp_done <= 1'b1;
                     resp_err  <= 1'b1;
                  end
               end
            end
            STORE: begin
               if (byte_idx == last_idx) begin
                  resp_done <= 1'b1;
                  resp_err  <= 1'b0;
               end
            end
            CAPTURE: begin
               resp_rdata <= load_result;
               resp_done  <= 1'b1;
               resp_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 64-byte RAM.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_done;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_WE;
   logic [5:0]  mem_add;
   logic [7:0]  mem_in;
   logic [31:0] mem_out;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(6)) dut (
      .LSU_clk    (clk),
      .LSU_rst    (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_done  (resp_done),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .mem_WE     (mem_WE),
      .mem_add    (mem_add),
      .mem_in     (mem_in),
      .mem_out    (mem_out)
   );

   // RAM model: byte write, registered 32-bit read of add..add+3 with wrap.
   logic [7:0] ram [0:63];
   logic       ram_ready = 1'b0;
   logic [5:0] ra1, ra2, ra3;
   assign ra1 = mem_add + 6'd1;
   assign ra2 = mem_add + 6'd2;
   assign ra3 = mem_add + 6'd3;

   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int j = 0; j < 64; j++) ram[j] <= 8'h55;
         ram_ready <= 1'b1;
      end else begin
         if (mem_WE === 1'b1) ram[mem_add] <= mem_in;
         mem_out <= {ram[ra3], ram[ra2], ram[ra1], ram[mem_add]};
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [5:0] a;
      logic [7:0] d;
   } wr_t;

   resp_t       rq[$];
   wr_t         wq[$];
   resp_t       mon_r;
   wr_t         mon_w;
   int          total = 0;
   int          bad   = 0;
   logic        mon_en = 1'b0;
   logic [31:0] last_rdata = 32'd0;
   int          acc1, acc2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every completion and every RAM write is matched against the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         if (resp_done === 1'b1) begin
            if (rq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done: resp_done=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
               mon_r = rq.pop_front();
               chk("done_cycle", cyc, mon_r.cyc);
               chk("resp_err", {31'd0, resp_err}, {31'd0, mon_r.err});
               chk("resp_rdata", resp_rdata, mon_r.rdata);
            end
         end
         if (mem_WE !== 1'b0) begin
            if (wq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write: mem_WE=%b add=%0d data=%h, no write expected", mem_WE, mem_add, mem_in);
            end else begin
               mon_w = wq.pop_front();
               chk("write_addr", {26'd0, mem_add}, {26'd0, mon_w.a});
               chk("write_data", {24'd0, mem_in}, {24'd0, mon_w.d});
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [5:0] a,
                        input logic [31:0] wd, input logic err, input logic [31:0] rd,
                        input int lat, output int acc);
      int    n;
      int    nb;
      resp_t e;
      wr_t   w;
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
      end
      acc     = cyc;
      e.err   = err;
      e.rdata = (we || err) ? last_rdata : rd;
      e.cyc   = cyc + 1 + lat;
      rq.push_back(e);
      if (!we && !err) last_rdata = rd;
      if (we && !err) begin
         nb = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
         for (int k = 0; k < nb; k++) begin
            w.a = a + 6'(k);
            w.d = wd[8*k +: 8];
            wq.push_back(w);
         end
      end
      @(posedge clk);
      #1;
      if (!we && !err) begin
         @(negedge clk);
         chk("load_rd_addr", {26'd0, mem_add}, {26'd0, a[5:2], 2'b00});
         chk("load_no_we", {31'd0, mem_WE}, 32'd0);
      end
   endtask

   task automatic drop();
      int n;
      req_valid = 1'b0;
      n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (rq.size() != 0 || wq.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d responses and %0d writes still outstanding", rq.size(), wq.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      wr_t w;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 6'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_done", {31'd0, resp_done}, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_we", {31'd0, mem_WE}, 32'd0);
      chk("rst_add", {26'd0, mem_add}, 32'd0);
      chk("rst_in", {24'd0, mem_in}, 32'd0);
      mon_en = 1'b1;

      // Reset during the second byte of SW to addr 0: bytes 0-1 land, 2-3 untouched.
      w.a = 6'd0; w.d = 8'hD4; wq.push_back(w);
      w.a = 6'd1; w.d = 8'hC3; wq.push_back(w);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 6'd0; req_wdata = 32'hA1B2C3D4;
      req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_we", {31'd0, mem_WE}, 32'd0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_done", {31'd0, resp_done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_ram", {ram[3], ram[2], ram[1], ram[0]}, 32'h5555C3D4);
      chk("abort_wq_empty", wq.size(), 32'd0);

      issue(1'b1, 3'b010, 6'd8,  32'hDEADBEEF, 1'b0, 32'd0, 4, acc1); drop();
      chk("sw_ram", {ram[11], ram[10], ram[9], ram[8]}, 32'hDEADBEEF);
      issue(1'b0, 3'b010, 6'd8,  32'd0, 1'b0, 32'hDEADBEEF, 2, acc1); drop();
      issue(1'b1, 3'b000, 6'd3,  32'h12345680, 1'b0, 32'd0, 1, acc1); drop();
      issue(1'b0, 3'b000, 6'd3,  32'd0, 1'b0, 32'hFFFFFF80, 2, acc1); drop();
      issue(1'b0, 3'b100, 6'd3,  32'd0, 1'b0, 32'h00000080, 2, acc1); drop();
      issue(1'b1, 3'b001, 6'd62, 32'hABCD8001, 1'b0, 32'd0, 2, acc1); drop();
      issue(1'b0, 3'b001, 6'd62, 32'd0, 1'b0, 32'hFFFF8001, 2, acc1); drop();
      issue(1'b0, 3'b101, 6'd62, 32'd0, 1'b0, 32'h00008001, 2, acc1); drop();
      issue(1'b0, 3'b000, 6'd1,  32'd0, 1'b0, 32'hFFFFFFC3, 2, acc1); drop();

      // Illegal: misaligned LW, misaligned SH, reserved load code.
      issue(1'b0, 3'b010, 6'd6,  32'd0, 1'b1, 32'd0, 0, acc1); drop();
      issue(1'b1, 3'b001, 6'd5,  32'h0000FFFF, 1'b1, 32'd0, 0, acc1); drop();
      issue(1'b0, 3'b011, 6'd0,  32'd0, 1'b1, 32'd0, 0, acc1); drop();
      chk("illegal_ram", {ram[6], ram[5]}, 32'h00005555);

      // req_valid held: LW accepted in the SW's resp_done cycle.
      issue(1'b1, 3'b010, 6'd16, 32'h11223344, 1'b0, 32'd0, 4, acc1);
      issue(1'b0, 3'b010, 6'd16, 32'd0, 1'b0, 32'h11223344, 2, acc2);
      drop();
      chk("b2b_no_gap", acc2, acc1 + 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
